microarch_trace_buffer: RTL and testbench

MICROARCH_TRACE_BUFFER -- requirements
Module: microarch_trace_buffer

---
 rtl/microarch_trace_buffer_if.sv | 24 ++
 rtl/microarch_trace_buffer.sv | 160 ++++++++++++++++
 tb/tb_microarch_trace_buffer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/microarch_trace_buffer_if.sv
// Record stream between the trace buffer (master) and its consumer (slave).
interface microarch_trace_buffer_if #(
    parameter int NUM_STAGES = 4,
    parameter int PC_W       = 32,
    parameter int TS_W       = 16
);
    logic                         rec_valid_o;
    logic                         rec_ready_i;
    logic [NUM_STAGES-1:0]        rec_mask_o;
    logic [NUM_STAGES*PC_W-1:0]   rec_pc_o;
    logic [31:0]                  rec_insn_o;
    logic [TS_W-1:0]              rec_cycle_o;
    logic                         rec_lost_o;

    modport master (
        output rec_valid_o, rec_mask_o, rec_pc_o, rec_insn_o, rec_cycle_o, rec_lost_o,
        input  rec_ready_i
    );

    modport slave (
        input  rec_valid_o, rec_mask_o, rec_pc_o, rec_insn_o, rec_cycle_o, rec_lost_o,
        output rec_ready_i
    );
endinterface

// File: rtl/microarch_trace_buffer.sv
// Pipeline trace buffer: collapses per-stage events of one cycle into a
// record, queues records in a FIFO with drop accounting, and tracks an
// end-of-trace handshake (finish instruction -> writeback -> drained).
module microarch_trace_buffer #(
    parameter int          NUM_STAGES  = 4,
    parameter int          DE_IDX      = 1,
    parameter int          PC_W        = 32,
    parameter int          DEPTH       = 16,
    parameter int          TS_W        = 16,
    parameter logic [31:0] FINISH_INSN = 32'h00002013,
    localparam int         AW          = $clog2(DEPTH),
    localparam int         LVL_W       = AW + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       if_req_i,
    input  logic [NUM_STAGES-1:0]      ev_valid_i,
    input  logic [NUM_STAGES*PC_W-1:0] ev_pc_i,
    input  logic [31:0]                de_insn_i,
    microarch_trace_buffer_if.master   rec_if,
    output logic [15:0]                drop_cnt_o,
    output logic [LVL_W-1:0]           level_o,
    output logic                       finish_o
);
    // Entry layout, LSB first: mask, pcs, insn, cycle, lost.
    localparam int PC_LSB  = NUM_STAGES;
    localparam int INS_LSB = PC_LSB + NUM_STAGES * PC_W;
    localparam int CYC_LSB = INS_LSB + 32;
    localparam int ENT_W   = CYC_LSB + TS_W + 1;

    typedef enum logic [1:0] {S_RUN, S_ARMED, S_DRAIN, S_DONE} state_t;

    state_t                    state_q;
    logic                      finish_q;
    logic                      prev_req_q;
    logic [PC_W-1:0]           prev_pc_q;
    logic [TS_W-1:0]           cycle_q;
    logic [15:0]               drop_cnt_q, drop_cnt_d;
    logic                      lost_q;
    logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]          count_q, count_d;
    logic [ENT_W-1:0]          mem_q [DEPTH];

    logic                      fetch_evt;
    logic [NUM_STAGES-1:0]     evt_mask;
    logic [NUM_STAGES*PC_W-1:0] evt_pc;
    logic [31:0]               evt_insn;
    logic                      any_evt, full, rec_valid, pop, push, drop;
    logic [ENT_W-1:0]          wr_ent, head;
    logic                      unused_ev0;

    // Lane 0 is driven by fetch requests; its valid bit is never consulted.
    assign unused_ev0 = ev_valid_i[0];

    // A fetch counts only on a request rising edge or a PC change.
    assign fetch_evt = if_req_i && (!prev_req_q || (ev_pc_i[PC_W-1:0] != prev_pc_q));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_lane
            if (gi == 0) begin : g_fetch
                assign evt_mask[gi] = fetch_evt;
            end else begin : g_stage
                assign evt_mask[gi] = ev_valid_i[gi];
            end
            assign evt_pc[gi*PC_W +: PC_W] = evt_mask[gi] ? ev_pc_i[gi*PC_W +: PC_W] : '0;
        end
    endgenerate

    assign evt_insn  = evt_mask[DE_IDX] ? de_insn_i : '0;
    assign any_evt   = |evt_mask;
    assign full      = (count_q == LVL_W'(DEPTH));
    assign rec_valid = (count_q != '0);
    assign pop       = rec_valid && rec_if.rec_ready_i;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push      = any_evt && (!full || pop);
    assign drop      = any_evt && !push;
    assign wr_ent    = {lost_q, cycle_q, evt_insn, evt_pc, evt_mask};
    assign count_d   = count_q + LVL_W'(push) - LVL_W'(pop);
    assign drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;

    // Record storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_ent;
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign rec_if.rec_valid_o = rec_valid;
    assign rec_if.rec_mask_o  = rec_valid ? head[0 +: NUM_STAGES]             : '0;
    assign rec_if.rec_pc_o    = rec_valid ? head[PC_LSB +: NUM_STAGES*PC_W]   : '0;
    assign rec_if.rec_insn_o  = rec_valid ? head[INS_LSB +: 32]               : '0;
    assign rec_if.rec_cycle_o = rec_valid ? head[CYC_LSB +: TS_W]             : '0;
    assign rec_if.rec_lost_o  = rec_valid ? head[ENT_W-1]                     : 1'b0;
    assign drop_cnt_o         = drop_cnt_q;
    assign level_o            = count_q;
    assign finish_o           = finish_q;

    // FIFO pointers, occupancy, cycle stamp, drop accounting, fetch history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_req_q <= 1'b0;
            prev_pc_q  <= '0;
            cycle_q    <= '0;
            drop_cnt_q <= '0;
            lost_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            prev_req_q <= if_req_i;
            prev_pc_q  <= ev_pc_i[PC_W-1:0];
            cycle_q    <= cycle_q + 1'b1;
            drop_cnt_q <= drop_cnt_d;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                lost_q   <= 1'b0;
            end else if (drop) begin
                lost_q   <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // End-of-trace FSM with registered finish flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            finish_q <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (ev_valid_i[DE_IDX] && (de_insn_i == FINISH_INSN)) begin
                        state_q <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (ev_valid_i[NUM_STAGES-1]) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((count_q == '0) && !push) begin
                        state_q  <= S_DONE;
                        finish_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_DONE;
                    finish_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_microarch_trace_buffer.sv
// Randomized + directed bench for microarch_trace_buffer with a queue-based
// reference model of the record stream, drops and end-of-trace.
module tb_microarch_trace_buffer;
    localparam int NS    = 4;
    localparam int PC_W  = 32;
    localparam int DEPTH = 16;
    localparam logic [31:0] FIN = 32'h00002013;

    logic         clk;
    logic         rst_n;
    logic         if_req;
    logic [NS-1:0] ev_valid;
    logic [NS*PC_W-1:0] ev_pc;
    logic [31:0]  de_insn;
    logic [15:0]  drop_cnt;
    logic [4:0]   level;
    logic         finish;

    int n_chk  = 0;
    int n_fail = 0;

    microarch_trace_buffer_if #(.NUM_STAGES(NS), .PC_W(PC_W), .TS_W(16)) rec_if ();

    microarch_trace_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req_i   (if_req),
        .ev_valid_i (ev_valid),
        .ev_pc_i    (ev_pc),
        .de_insn_i  (de_insn),
        .rec_if     (rec_if),
        .drop_cnt_o (drop_cnt),
        .level_o    (level),
        .finish_o   (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [NS-1:0]      mask;
        logic [NS*PC_W-1:0] pc;
        logic [31:0]        insn;
        logic [15:0]        cyc;
        logic               lost;
    } rec_t;

    rec_t        q[$];
    int          m_cyc;
    bit          m_prev_req;
    logic [31:0] m_prev_pc;
    int          m_drop;
    bit          m_lost;
    int          m_phase;   // 0 run, 1 armed, 2 drain, 3 done

    task automatic model_reset();
        q.delete();
        m_cyc = 0; m_prev_req = 0; m_prev_pc = '0;
        m_drop = 0; m_lost = 0; m_phase = 0;
    endtask

    task automatic model_step();
        rec_t r;
        bit fe, pop, push;
        int lvl;
        fe = if_req && (!m_prev_req || (ev_pc[31:0] != m_prev_pc));
        r.mask = {ev_valid[NS-1:1], fe};
        for (int s = 0; s < NS; s++)
            r.pc[s*PC_W +: PC_W] = r.mask[s] ? ev_pc[s*PC_W +: PC_W] : 32'h0;
        r.insn = r.mask[1] ? de_insn : 32'h0;
        r.cyc  = 16'(m_cyc);
        r.lost = m_lost;
        lvl  = q.size();
        pop  = (lvl > 0) && rec_if.rec_ready_i;
        push = 0;
        if (r.mask != '0) begin
            if (lvl < DEPTH || pop) push = 1;
            else begin
                if (m_drop < 65535) m_drop++;
                m_lost = 1;
            end
        end
        case (m_phase)
            0: if (ev_valid[1] && de_insn == FIN) m_phase = 1;
            1: if (ev_valid[NS-1]) m_phase = 2;
            2: if (lvl == 0 && !push) m_phase = 3;
            default: m_phase = 3;
        endcase
        if (pop) begin
            $display("pop  stamp=%0d mask=%b pc0=%h insn=%h lost=%0d",
                     q[0].cyc, q[0].mask, q[0].pc[31:0], q[0].insn, q[0].lost);
            void'(q.pop_front());
        end
        if (push) begin
            q.push_back(r);
            m_lost = 0;
        end
        m_prev_req = if_req;
        m_prev_pc  = ev_pc[31:0];
        m_cyc      = (m_cyc + 1) % 65536;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    task automatic compare();
        bit v;
        v = (q.size() > 0);
        chk("rec_valid", 128'(rec_if.rec_valid_o), 128'(v));
        chk("rec_mask",  128'(rec_if.rec_mask_o),  v ? 128'(q[0].mask) : 128'h0);
        chk("rec_pc",    rec_if.rec_pc_o,          v ? q[0].pc : 128'h0);
        chk("rec_insn",  128'(rec_if.rec_insn_o),  v ? 128'(q[0].insn) : 128'h0);
        chk("rec_cycle", 128'(rec_if.rec_cycle_o), v ? 128'(q[0].cyc) : 128'h0);
        chk("rec_lost",  128'(rec_if.rec_lost_o),  v ? 128'(q[0].lost) : 128'h0);
        chk("level",     128'(level),              128'(q.size()));
        chk("drop_cnt",  128'(drop_cnt),           128'(m_drop));
        chk("finish",    128'(finish),             128'(m_phase == 3));
    endtask

    task automatic drive(input bit req, input logic [NS-1:0] v, input logic [31:0] pc0,
                         input logic [31:0] insn, input bit rdy);
        if_req   = req;
        ev_valid = v;
        ev_pc    = {$urandom(), $urandom(), $urandom(), pc0};
        de_insn  = insn;
        rec_if.rec_ready_i = rdy;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        logic [127:0] exp_pc;
        logic [31:0]  ri;
        bit           rdy;
        rst_n = 1'b0;
        drive(0, '0, 32'h0, 32'h0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", 128'(rec_if.rec_valid_o), 128'h0);
        chk("rst_level", 128'(level), 128'h0);
        chk("rst_mask",  128'(rec_if.rec_mask_o), 128'h0);
        chk("rst_cycle", 128'(rec_if.rec_cycle_o), 128'h0);
        chk("rst_finish", 128'(finish), 128'h0);
        rst_n = 1'b1;

        // Fetch dedup: same PC for 3 cycles then a new PC -> 2 records.
        for (int i = 0; i < 4; i++) begin
            drive(1, '0, (i < 3) ? 32'h100 : 32'h104, 32'h0, 0);
            step();
        end
        chk("dedup_level", 128'(level), 128'd2);
        chk("dedup_mask0", 128'(rec_if.rec_mask_o), 128'h1);
        chk("dedup_pc0",   rec_if.rec_pc_o, 128'h100);
        drive(0, '0, 32'h0, 32'h0, 1);
        step();
        chk("dedup_pc1",   rec_if.rec_pc_o, 128'h104);
        step();

        // Multi-stage record, stamped with the event cycle (counter value 6).
        if_req = 0; ev_valid = 4'b1111; ev_pc = {32'h30, 32'h20, 32'h10, 32'h55};
        de_insn = 32'h1234_5678; rec_if.rec_ready_i = 0;
        step();
        exp_pc = {32'h30, 32'h20, 32'h10, 32'h0};
        chk("multi_mask",  128'(rec_if.rec_mask_o), 128'hE);
        chk("multi_pc",    rec_if.rec_pc_o, exp_pc);
        chk("multi_cycle", 128'(rec_if.rec_cycle_o), 128'd6);
        chk("multi_insn",  128'(rec_if.rec_insn_o), 128'h1234_5678);
        drive(0, '0, 32'h0, 32'h0, 1);
        step();

        // Overflow: 20 events with no consumer -> 16 stored, 4 dropped.
        for (int i = 0; i < 20; i++) begin
            drive(0, 4'b1000, 32'h0, 32'h0, 0);
            step();
        end
        chk("ovf_level", 128'(level), 128'd16);
        chk("ovf_drop",  128'(drop_cnt), 128'd4);
        for (int i = 0; i < 16; i++) begin
            drive(0, '0, 32'h0, 32'h0, 1);
            step();
        end
        chk("drain_level", 128'(level), 128'd0);
        drive(0, 4'b0100, 32'h0, 32'h0, 0);
        step();
        chk("lost_first", 128'(rec_if.rec_lost_o), 128'h1);
        drive(0, 4'b0100, 32'h0, 32'h0, 1);
        step();
        chk("lost_second", 128'(rec_if.rec_lost_o), 128'h0);
        drive(0, '0, 32'h0, 32'h0, 1);
        step();

        // Full FIFO with simultaneous push and pop: no drop.
        for (int i = 0; i < 16; i++) begin
            drive(0, 4'b1000, 32'h0, 32'h0, 0);
            step();
        end
        drive(0, 4'b1000, 32'h0, 32'h0, 1);
        step();
        chk("full_pp_level", 128'(level), 128'd16);
        chk("full_pp_drop",  128'(drop_cnt), 128'd4);

        // Randomized traffic with periodic consumer stalls.
        for (int i = 0; i < 300; i++) begin
            ri = $urandom();
            if (ri == FIN) ri = ri ^ 32'h1;
            rdy = ((i % 40) < 25) ? ($urandom_range(0, 3) != 0) : 1'b0;
            drive($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 1) ? 32'h100 : 32'h104, ri, rdy);
            step();
        end

        // Asynchronous reset with records buffered clears state without a clock.
        for (int i = 0; i < 20; i++) begin
            drive(0, '0, 32'h0, 32'h0, 1);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'b0010, 32'h0, 32'h0, 0);
            step();
        end
        chk("pre_rst_level", 128'(level), 128'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(rec_if.rec_valid_o), 128'h0);
        chk("arst_level", 128'(level), 128'h0);
        chk("arst_drop",  128'(drop_cnt), 128'h0);
        model_reset();
        drive(0, '0, 32'h0, 32'h0, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // End of trace: writeback in the arming cycle must not count.
        drive(0, 4'b1010, 32'h0, FIN, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, 32'h0, 32'h0, 1);
            step();
        end
        chk("armed_no_finish", 128'(finish), 128'h0);
        drive(0, 4'b1000, 32'h0, 32'h0, 1);
        step();
        for (int i = 0; i < 20 && finish !== 1'b1; i++) begin
            drive(0, '0, 32'h0, 32'h0, 1);
            step();
        end
        chk("finish_rise", 128'(finish), 128'h1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'b1110, 32'h200 + 32'(i * 4), 32'h0, 1);
            step();
        end
        chk("finish_hold", 128'(finish), 128'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
